// File: rtl/serial_mod_adder.sv
// serial_mod_adder: digit-serial modular adder/subtractor, LS digit first.
//
// Adds or subtracts two DW*NDIG-bit words presented one DW-bit digit per
// accepted cycle. The carry/borrow chains between digits through an internal
// register, and a start/done handshake frames each word.
//
// Optional feature: define SERIAL_MOD_ADDER_WORD_EN to add word_out, which
// assembles the full parallel result as the digits stream out.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   clr        synchronous abort back to IDLE; partial word discarded
//   start      begin a word (accepted only in IDLE)
//   sub_mode   sampled with start: 0 = A+B, 1 = A-B
//   in_valid   a_in/b_in digit valid (consumed only in RUN)
//   a_in       operand A digit
//   b_in       operand B digit
//   busy       high while in RUN
//   out_valid  one-cycle pulse per result digit
//   sum_out    result digit, held between pulses
//   last_out   final digit marker, coincident with out_valid
//   done       one-cycle pulse with the final digit
//   carry_out  final carry (subtract: 1 = no borrow), held until next start
//   word_out   full result, LS digit in [DW-1:0] (SERIAL_MOD_ADDER_WORD_EN only)
module serial_mod_adder #(
  parameter int DW   = 8,
  parameter int NDIG = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          start,
  input  logic          sub_mode,
  input  logic          in_valid,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic          busy,
  output logic          out_valid,
  output logic [DW-1:0] sum_out,
  output logic          last_out,
  output logic          done,
`ifdef SERIAL_MOD_ADDER_WORD_EN
  output logic [DW*NDIG-1:0] word_out,
`endif
  output logic          carry_out
);
  localparam int W  = DW * NDIG;
  localparam int CW = $clog2(NDIG);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q;
  logic            sub_q;
  logic            carry_q;
  logic [CW-1:0]   cnt_q;
  logic            out_valid_q;
  logic [DW-1:0]   sum_q;
  logic            last_q;
  logic            done_q;
  logic            carry_out_q;
  logic [DW:0]     sum_d;
  logic            last_dig;
`ifdef SERIAL_MOD_ADDER_WORD_EN
  logic [W-1:0]    word_q;
`endif

  // Subtraction is A + ~B + 1: the +1 comes from seeding carry with sub_mode.
  assign sum_d    = {1'b0, a_in} + {1'b0, sub_q ? ~b_in : b_in} + {{DW{1'b0}}, carry_q};
  assign last_dig = cnt_q == CW'(NDIG - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      carry_out_q <= 1'b0;
`ifdef SERIAL_MOD_ADDER_WORD_EN
      word_q      <= '0;
`endif
    end else begin
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      if (clr) begin
        state_q     <= IDLE;
        carry_q     <= 1'b0;
        cnt_q       <= '0;
        carry_out_q <= 1'b0;
`ifdef SERIAL_MOD_ADDER_WORD_EN
        word_q      <= '0;
`endif
      end else if (state_q == IDLE) begin
        if (start) begin
          state_q     <= RUN;
          sub_q       <= sub_mode;
          carry_q     <= sub_mode;
          cnt_q       <= '0;
          carry_out_q <= 1'b0;
`ifdef SERIAL_MOD_ADDER_WORD_EN
          word_q      <= '0;
`endif
        end
      end else if (in_valid) begin
        out_valid_q <= 1'b1;
        sum_q       <= sum_d[DW-1:0];
        carry_q     <= sum_d[DW];
`ifdef SERIAL_MOD_ADDER_WORD_EN
        word_q      <= {sum_d[DW-1:0], word_q[W-1:DW]};
`endif
        if (last_dig) begin
          last_q      <= 1'b1;
          done_q      <= 1'b1;
          carry_out_q <= sum_d[DW];
          state_q     <= IDLE;
          cnt_q       <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign busy      = state_q == RUN;
  assign out_valid = out_valid_q;
  assign sum_out   = sum_q;
  assign last_out  = last_q;
  assign done      = done_q;
  assign carry_out = carry_out_q;
`ifdef SERIAL_MOD_ADDER_WORD_EN
  assign word_out  = word_q;
`endif
endmodule

// File: doc/serial_mod_adder.md
Name: serial_mod_adder

Overview:
- Digit-serial modular adder/subtractor for the serialized SEED datapath.
- Processes one DW-bit digit per accepted cycle, least-significant digit first, over NDIG digits.
- Default configuration performs the 32-bit mod-2^32 add/sub of the G/round-key path on 8-bit digits.
- Carry/borrow propagates between digits in an internal register; a start/done handshake frames each word.

Parameters:
DW, 8, digit width in bits (≥1)
NDIG, 4, digits per word (≥2); word width = DW*NDIG

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous abort; returns block to IDLE
start  input  1  begin new word operation (accepted only in IDLE)
sub_mode  input  1  sampled on accepted start; 0 = A+B, 1 = A−B
in_valid  input  1  a_in/b_in digit valid (consumed only in RUN)
a_in  input  DW  operand A digit
b_in  input  DW  operand B digit
busy  output  1  high while in RUN
out_valid  output  1  sum_out valid (one-cycle pulse per digit)
sum_out  output  DW  result digit
last_out  output  1  marks the final digit of the word, coincident with out_valid
done  output  1  one-cycle pulse with the final digit
carry_out  output  1  final carry; in subtract mode 1 = no borrow; held until next start

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE; busy, out_valid, last_out, done, carry_out = 0; sum_out = 0.
  - Internal carry = 0; digit counter = 0.
- States: IDLE and RUN; busy = (state == RUN).
- IDLE:
  - start = 1 → RUN, latch sub_mode, carry ← sub_mode, counter ← 0, carry_out ← 0.
  - in_valid is ignored in IDLE.
- RUN, in_valid = 1:
  - s[DW:0] = a_in + (sub ? ~b_in : b_in) + carry.
  - sum_out ← s[DW-1:0], out_valid ← 1, carry ← s[DW], counter + 1.
  - Latency is 1 cycle from digit accept to out_valid.
- RUN, in_valid = 0: state, carry and counter hold; out_valid ← 0 (gaps of any length allowed).
- Final digit (counter == NDIG−1 and in_valid):
  - last_out ← 1, done ← 1, carry_out ← s[DW], state ← IDLE, counter ← 0.
- out_valid, last_out and done are registered single-cycle pulses; sum_out holds its last value otherwise.
- start in RUN is ignored; the operation in progress is unaffected.
- Back-to-back words: start is accepted in the same cycle done is high (state is already IDLE). The first digit may be presented the following cycle.
- Arithmetic is modulo 2^(DW*NDIG); overflow/borrow appears only on carry_out and never alters the digit stream.
- clr (synchronous, highest priority after reset):
  - state ← IDLE, carry and counter ← 0.
  - out_valid, last_out, done ← 0; carry_out ← 0.
  - A partial word is discarded; no done is issued for it.
- start and clr in the same cycle: clr wins and start is dropped.
- rst_n asserted mid-word: same end state as reset; no partial output.

Optional Feature:
Macro: SERIAL_MOD_ADDER_WORD_EN
- Defined:
  - Adds output word_out [DW*NDIG-1:0].
  - Cleared to 0 on reset, clr and accepted start.
  - On each out_valid digit it shifts right by DW with the new digit entering the top DW bits.
  - After done it holds the full parallel result, least-significant digit in bits [DW-1:0], until the next start.
- Not defined: port and register are absent; all other behaviour is identical.

Test Plan:
- Add 0x12345678 + 0x9ABCDEF0 (digits LS first, contiguous) → sum_out 0x68, 0x35, 0xF1, 0xAC on consecutive cycles; last_out and done with 0xAC; carry_out = 0; word_out = 0xACF13568 when the macro is defined.
- Wrap: 0xFFFFFFFF + 0x00000001 → digits 0x00 ×4; carry_out = 1.
- Subtract: sub_mode = 1, 0x00000000 − 0x00000001 → digits 0xFF ×4, carry_out = 0. Then 0x00000005 − 0x00000003 → 0x02, 0x00, 0x00, 0x00, carry_out = 1.
- Gapped input: the first add case with in_valid low for 3 cycles between digits 1 and 2 → identical digits and carry_out; busy stays high through the gap; done only after the 4th digit.
- Abort/robustness: clr after 2 digits → busy = 0, no done, carry_out = 0; a following word computes correctly. Also: start while busy is ignored; rst_n pulsed mid-word gives all outputs 0.
- Back-to-back: start asserted in the done cycle, second word 0x00000001 + 0x00000001 → 0x02, 0x00, 0x00, 0x00 with no lost cycle.
